gf2_matvec_seq: RTL and testbench
=================================

Name: gf2_matvec_seq

Overview:
- Sequential GF(2) matrix-vector multiplier: u = M·v, with AND as multiply and XOR as add.
- Accepts an n×n binary matrix and an n-bit vector through a valid/ready handshake.
- Time-shares one combinational row-dot unit, computing one output bit per clock.
- Returns u through a valid/ready handshake; a low-area alternative to the fully parallel combinational multiplier.

Parameters:
- N, 3, matrix dimension (N ≥ 2).
- CNT_W, $clog2(N) (min 1), row-index counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  M_flat and v_in are valid.
- in_ready  output  1  block can accept an operand set.
- M_flat  input  N*N  matrix, M[i][j] = M_flat[i*N+j]; row i = M_flat[i*N +: N].
- v_in  input  N  vector, v[j] = v_in[j].
- out_valid  output  1  u_out holds the finished result.
- out_ready  input  1  consumer accepts u_out.
- u_out  output  N  result, u[i] = XOR over j of (M[i][j] & v[j]).
- busy  output  1  high while in COMPUTE.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, u_out=0, row counter=0.
- Reset is asynchronous. Asserting it mid-computation aborts the operation; no partial result is ever flagged valid.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: register M_flat and v_in; clear the u register; row=0; go to COMPUTE.
- COMPUTE:
  - in_ready=0, busy=1.
  - Each clock writes u[row] = ^(M_row(row) & v_reg), then row increments.
  - After writing row N-1: row=0; go to DONE.
- DONE:
  - out_valid=1 and u_out stable.
  - in_ready=0; new inputs are not accepted while holding a result.
  - On out_ready: out_valid drops next edge; go to IDLE.
- Latency: out_valid rises exactly N clocks after the accepting edge. Throughput is one operation per N+2 clocks with out_ready held high.
- Input changes after acceptance have no effect; operands are registered.
- in_valid asserted during COMPUTE or DONE is ignored (in_ready low). The requester must hold it until accepted.
- out_ready while out_valid=0 has no effect.
- u_out reads as the u register at all times. It is only meaningful while out_valid=1.
- The row counter never exceeds N-1; no wrap-around state is reachable.

Optional Feature:
- Macro: GF2_MATVEC_ITER_EN.
- With the macro defined:
  - Adds port iter, input, 8 bits, sampled with the operands. The block computes u = M^iter · v.
  - After each full pass, if passes remain: v_reg ← u, row=0, stay in COMPUTE.
  - Latency is N*iter clocks.
  - iter=0: go straight to DONE with u = v_in one clock after acceptance.
- Without the macro: no iter port; single pass as specified above.

Decomposition:
- Package gf2_matvec_pkg:
  - state encoding constants IDLE=2'd0, COMPUTE=2'd1, DONE=2'd2;
  - function row_slice(M, i) returning the N-bit row.
- Sub-module gf2_row_dot (parameter N; inputs row[N-1:0] and vec[N-1:0]; output bit = ^(row & vec)).
  - Purely combinational.
  - Instantiated once in gf2_matvec_seq.

Test Plan (N=3):
- Reset: rst_n low → in_ready=1, out_valid=0, busy=0, u_out=000. Pulse rst_n low during COMPUTE → back to IDLE, out_valid never asserts.
- Identity: M_flat=9'h111, v_in=3'b101 → out_valid exactly 3 clocks after acceptance, u_out=3'b101.
- All-ones: M_flat=9'h1FF, v_in=3'b011 → u_out=000. Same M with v_in=3'b111 → u_out=111.
- Backpressure:
  - M_flat=9'h022 (M[0][1]=M[1][2]=1), v_in=3'b110 → u_out=3'b011.
  - Hold out_ready=0 for 5 clocks → out_valid and u_out stable, in_ready=0; a second in_valid is not accepted.
  - Release out_ready → IDLE next clock, then the second operation is accepted.
- Exhaustive: all 2^12 (M_flat, v_in) pairs against a bench reference model; u_out matches for every pair, out_ready randomly stalled.
- GF2_MATVEC_ITER_EN: M_flat=9'h022, v_in=3'b110.
  - iter=2 → u_out=3'b001 after 6 clocks.
  - iter=3 → 3'b000 after 9 clocks.
  - iter=0 → 3'b110 after 1 clock.

Source files
------------

// File: rtl/gf2_matvec_pkg.sv
// Shared definitions for the sequential GF(2) matrix-vector multiplier.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: FSM state encoding and row_slice(), which extracts row i of a
// row-major flattened n x n bit matrix.
package gf2_matvec_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Largest matrix dimension row_slice() can handle.
  localparam int MAX_N  = 16;
  localparam int MAX_MW = MAX_N * MAX_N;

  // Row i of an n x n matrix stored as M[i][j] = m[i*n+j]; bits >= n read 0.
  function automatic logic [MAX_N-1:0] row_slice(input logic [MAX_MW-1:0] m,
                                                 input int n, input int i);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int j = 0; j < MAX_N; j++) begin
      if (j < n) r[j] = m[i*n + j];
    end
    return r;
  endfunction

endpackage

// File: rtl/gf2_row_dot.sv
// GF(2) dot product of one matrix row with a vector: AND then XOR-reduce.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: row[N-1:0], vec[N-1:0] in; dot = ^(row & vec) out.
module gf2_row_dot #(
  parameter int N = 3
) (
  input  logic [N-1:0] row,
  input  logic [N-1:0] vec,
  output logic         dot
);

  assign dot = ^(row & vec);

endmodule

// File: rtl/gf2_matvec_seq.sv
// Sequential GF(2) matrix-vector multiply u = M*v, one output bit per clock.
// Latency: out_valid rises N clocks after the accepting edge (N*iter with iteration).
// Backpressure: in_ready low while computing or holding a result; result held until out_ready.
// Ports: clk, rst_n (async, active low); in_valid/in_ready with M_flat (row-major,
// M[i][j] = M_flat[i*N+j]) and v_in; out_valid/out_ready with u_out; busy in COMPUTE.
// Optional macro GF2_MATVEC_ITER_EN adds 8-bit input iter and computes u = M^iter * v.
module gf2_matvec_seq
  import gf2_matvec_pkg::*;
#(
  parameter int N     = 3,                         // 2 <= N <= MAX_N
  parameter int CNT_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*N-1:0] M_flat,
  input  logic [N-1:0]   v_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   u_out,
  output logic           busy
`ifdef GF2_MATVEC_ITER_EN
  ,
  input  logic [7:0]     iter
`endif
);

  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(N - 1);

  state_t           state;
  logic [N*N-1:0]   m_reg;
  logic [N-1:0]     v_reg;
  logic [N-1:0]     u_reg;
  logic [CNT_W-1:0] row;
  logic [N-1:0]     row_vec;
  logic             dot;
  logic [N-1:0]     u_next;
  logic             skip_pass;   // iter==0: result is the vector itself
  logic             last_pass;   // the pass now running is the final one

`ifdef GF2_MATVEC_ITER_EN
  logic [7:0]       pass_left;
  assign skip_pass = (pass_left == 8'd0);
  assign last_pass = (pass_left == 8'd1);
`else
  assign skip_pass = 1'b0;
  assign last_pass = 1'b1;
`endif

  assign row_vec = N'(row_slice(MAX_MW'(m_reg), N, int'(row)));

  gf2_row_dot #(.N(N)) u_dot (
    .row (row_vec),
    .vec (v_reg),
    .dot (dot)
  );

  // Current u with the bit for this row replaced; also the next-pass vector.
  always_comb begin
    u_next      = u_reg;
    u_next[row] = dot;
  end

  assign u_out = u_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m_reg     <= '0;
      v_reg     <= '0;
      u_reg     <= '0;
      row       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef GF2_MATVEC_ITER_EN
      pass_left <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg    <= M_flat;
            v_reg    <= v_in;
            u_reg    <= '0;
            row      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= COMPUTE;
`ifdef GF2_MATVEC_ITER_EN
            pass_left <= iter;
`endif
          end
        end
        COMPUTE: begin
          if (skip_pass) begin
            u_reg     <= v_reg;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            u_reg <= u_next;
            if (row == ROW_LAST) begin
              row <= '0;
              if (last_pass) begin
                busy      <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                // Feed this pass's result back as the vector for the next one.
                v_reg <= u_next;
`ifdef GF2_MATVEC_ITER_EN
                pass_left <= pass_left - 8'd1;
`endif
              end
            end else begin
              row <= row + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_matvec_seq.sv
// Testbench for gf2_matvec_seq (N=3): vector table, hand-written handshake
// sequences, exhaustive operand sweep with random output stalls, and the
// iteration feature when GF2_MATVEC_ITER_EN is defined.
module tb_gf2_matvec_seq;
  localparam int N = 3;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*N-1:0] M_flat;
  logic [N-1:0]   v_in;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   u_out;
  logic           busy;
`ifdef GF2_MATVEC_ITER_EN
  logic [7:0]     iter;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [8:0] m;
    logic [2:0] v;
    logic [2:0] u;
  } vec_t;
  vec_t tbl[6];

  gf2_matvec_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M_flat    (M_flat),
    .v_in      (v_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .u_out     (u_out),
    .busy      (busy)
`ifdef GF2_MATVEC_ITER_EN
    ,
    .iter      (iter)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Reference: u[i] is the parity of the number of positions where row i and v are both 1.
  function automatic logic [2:0] ref_mv(input logic [8:0] m, input logic [2:0] v);
    logic [2:0] u;
    logic [2:0] r;
    for (int i = 0; i < N; i++) begin
      r    = 3'(m >> (i * N));
      u[i] = (($countones(r & v) % 2) == 1);
    end
    return u;
  endfunction

  function automatic logic [2:0] ref_iter(input logic [8:0] m, input logic [2:0] v, input int it);
    logic [2:0] u;
    u = v;
    for (int k = 0; k < it; k++) u = ref_mv(m, u);
    return u;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one operation from an IDLE-phase negedge and ends on a negedge in IDLE.
  task automatic run_op(input logic [8:0] m, input logic [2:0] v, input logic [2:0] exp_u,
                        input int exp_lat, input int stall, input bit early, input bit full);
    int w;
    int lat;
    in_valid  = 1'b1;
    M_flat    = m;
    v_in      = v;
    out_ready = early;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    M_flat   = 9'($urandom);
    v_in     = 3'($urandom);
    if (full) check("busy_in_compute", {30'd0, busy, in_ready}, 32'b10);
    lat = 0;
    while (!out_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      check("done_timeout", 32'd0, 32'd1);
      out_ready = 1'b0;
      return;
    end
    check("u_out", {29'd0, u_out}, {29'd0, exp_u});
    if (full) check("latency", lat, exp_lat);
    if (!early) begin
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
    end
    @(negedge clk);
    if (full) check("release_to_idle", {29'd0, out_valid, in_ready, busy}, 32'b010);
    out_ready = 1'b0;
  endtask

  initial begin
    int   w;
    int   lat;
    int   acc;
    bit   seen;
    logic [8:0] m;
    logic [2:0] v;

    tbl[0] = '{m: 9'h111, v: 3'b101, u: 3'b101};
    tbl[1] = '{m: 9'h1FF, v: 3'b011, u: 3'b000};
    tbl[2] = '{m: 9'h1FF, v: 3'b111, u: 3'b111};
    tbl[3] = '{m: 9'h022, v: 3'b110, u: 3'b011};
    tbl[4] = '{m: 9'h0E0, v: 3'b101, u: 3'b110};
    tbl[5] = '{m: 9'h007, v: 3'b111, u: 3'b001};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    M_flat    = '0;
    v_in      = '0;
`ifdef GF2_MATVEC_ITER_EN
    iter      = 8'd1;
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, in_ready, out_valid, busy, u_out}, {26'd0, 3'b100, 3'b000});
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors.
    for (int i = 0; i < 6; i++)
      run_op(tbl[i].m, tbl[i].v, tbl[i].u, N, i % 3, 1'b0, 1'b1);

    // Backpressure: hold the result 5 clocks while a second request waits.
    in_valid = 1'b1; M_flat = 9'h022; v_in = 3'b110; out_ready = 1'b0;
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    M_flat = 9'h111; v_in = 3'b010;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bp_first_latency", lat, N);
    check("bp_first_u", {29'd0, u_out}, 32'b011);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", {27'd0, out_valid, u_out, in_ready}, {27'd0, 1'b1, 3'b011, 1'b0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", {29'd0, out_valid, in_ready, busy}, 32'b010);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", {30'd0, busy, in_ready}, 32'b10);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bp_second_latency", lat, N);
    check("bp_second_u", {29'd0, u_out}, 32'b010);
    @(negedge clk);
    out_ready = 1'b0;

    // Throughput: back-to-back requests with out_ready high, one accept per N+2 clocks.
    in_valid = 1'b1; M_flat = 9'h111; v_in = 3'b101; out_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 2 * (N + 2); k++) begin
      if (in_ready && in_valid) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("throughput_accepts", acc, 2);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("throughput_drain", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Reset in the middle of a computation aborts it.
    in_valid = 1'b1; M_flat = 9'h1FF; v_in = 3'b111;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_reset_outputs", {26'd0, in_ready, out_valid, busy, u_out}, {26'd0, 3'b100, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < N + 3; k++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("abort_no_valid", {31'd0, seen}, 32'd0);
    check("abort_idle_ready", {31'd0, in_ready}, 32'd1);

    // Exhaustive sweep of all operand pairs with random output stalls.
    for (int p = 0; p < 4096; p++) begin
      m = 9'(p);
      v = 3'(p >> 9);
      run_op(m, v, ref_mv(m, v), N, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b1);
    end

`ifdef GF2_MATVEC_ITER_EN
    iter = 8'd2; run_op(9'h022, 3'b110, 3'b001, 2 * N, 1, 1'b0, 1'b1);
    iter = 8'd3; run_op(9'h022, 3'b110, 3'b000, 3 * N, 0, 1'b1, 1'b1);
    iter = 8'd0; run_op(9'h022, 3'b110, 3'b110, 1, 2, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      int it;
      it   = $urandom_range(0, 6);
      iter = 8'(it);
      m    = 9'($urandom);
      v    = 3'($urandom);
      run_op(m, v, ref_iter(m, v, it), (it == 0) ? 1 : N * it,
             $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
